// File: rtl/mips_multicycle_core_if.sv
// Memory bus between the multi-cycle core (master) and a shared
// instruction/data memory (slave). The request stays up until a one-cycle ack.
interface mips_multicycle_core_if #(
    parameter int ADDR_W = 8
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: one FSM shares an ALU and a single memory port.
// Optional feature macro: MC_TIMEOUT_EN (memory ack timeout -> err + HALT).
// The next request (fetch or data access) is issued on the transition into the
// state that waits for it, so a zero-wait memory acks in that state's first cycle.
module mips_multicycle_core #(
    parameter int          ADDR_W      = 8,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          MEM_TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    mips_multicycle_core_if.master    mem,
    output logic [ADDR_W-1:0]         pc_out,
    output logic [2:0]                state_out,
    output logic                      halted,
    output logic                      err
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [31:0]       ir_reg, a_reg, b_reg, alu_reg, mdr_reg;
    logic [ADDR_W-1:0] target_reg;
    logic              mem_req_reg, mem_we_reg, halted_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;
    logic              timeout_hit;

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [31:0] imm32;
    assign opcode = ir_reg[31:26];
    assign rs     = ir_reg[25:21];
    assign rt     = ir_reg[20:16];
    assign rd     = ir_reg[15:11];
    assign funct  = ir_reg[5:0];
    assign imm32  = {{16{ir_reg[15]}}, ir_reg[15:0]};

    // Register file: $0 is hard-wired, $1..$31 are individual reset flops.
    logic [31:0] rf [32];
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    assign wb_en   = (state_reg == S_WB);
    assign wb_addr = (opcode == OP_RTYPE) ? rd : rt;
    assign wb_data = (opcode == OP_LW) ? mdr_reg : alu_reg;
    assign rf[0]   = 32'd0;

    for (genvar gi = 1; gi < 32; gi++) begin : g_rf
        logic [31:0] q_reg;
        // Write-back port for register gi.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)                                  q_reg <= '0;
            else if (wb_en && wb_addr == 5'(gi))       q_reg <= wb_data;
        end
        assign rf[gi] = q_reg;
    end

    // Shared ALU, branch/jump target and effective address arithmetic.
    logic [31:0] pc32, br_sum, j32, ea, alu_res;
    logic        funct_ok;
    always_comb begin
        pc32               = '0;
        pc32[ADDR_W-1:0]   = pc_reg;
        br_sum             = pc32 + (imm32 << 2);
        j32                = {pc32[31:28], ir_reg[25:0], 2'b00};
        ea                 = a_reg + imm32;
        alu_res            = '0;
        funct_ok           = 1'b1;
        case (funct)
            6'h20:   alu_res = a_reg + b_reg;
            6'h22:   alu_res = a_reg - b_reg;
            6'h24:   alu_res = a_reg & b_reg;
            6'h25:   alu_res = a_reg | b_reg;
            6'h2A:   alu_res = {31'd0, $signed(a_reg) < $signed(b_reg)};
            default: funct_ok = 1'b0;
        endcase
    end

    // Upper address bits are dropped on purpose when ADDR_W < 32.
    logic unused_ok;
    assign unused_ok = ^{ir_reg[10:6], br_sum, ea, j32};

`ifdef MC_TIMEOUT_EN
    logic [15:0] wait_cnt_reg;
    logic        err_reg;
    assign timeout_hit = mem_req_reg && !mem.mem_ack &&
                         (wait_cnt_reg == 16'(MEM_TIMEOUT - 1));
    // Count consecutive unacknowledged request cycles; latch err on expiry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (mem_req_reg && !mem.mem_ack && !timeout_hit) wait_cnt_reg <= wait_cnt_reg + 16'd1;
            else                                             wait_cnt_reg <= '0;
            if (timeout_hit) err_reg <= 1'b1;
        end
    end
    assign err = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // Main control FSM with registered bus outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_FETCH;
            pc_reg        <= RESET_PC[ADDR_W-1:0];
            ir_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            alu_reg       <= '0;
            mdr_reg       <= '0;
            target_reg    <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            halted_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (timeout_hit) begin
                        mem_req_reg <= 1'b0;
                        halted_reg  <= 1'b1;
                        state_reg   <= S_HALT;
                    end else if (!mem_req_reg) begin
                        // Only after reset: nobody issued this fetch yet.
                        mem_req_reg  <= 1'b1;
                        mem_we_reg   <= 1'b0;
                        mem_addr_reg <= pc_reg;
                    end else if (mem.mem_ack) begin
                        ir_reg      <= mem.mem_rdata;
                        pc_reg      <= pc_reg + ADDR_W'(4);
                        mem_req_reg <= 1'b0;
                        state_reg   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_reg      <= rf[rs];
                    b_reg      <= rf[rt];
                    target_reg <= br_sum[ADDR_W-1:0];
                    case (opcode)
                        OP_J: begin
                            pc_reg       <= j32[ADDR_W-1:0];
                            mem_req_reg  <= 1'b1;
                            mem_we_reg   <= 1'b0;
                            mem_addr_reg <= j32[ADDR_W-1:0];
                            state_reg    <= S_FETCH;
                        end
                        OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_reg <= S_EXEC;
                        OP_HALT: begin
                            halted_reg <= 1'b1;
                            state_reg  <= S_HALT;
                        end
                        default: begin
                            halted_reg <= 1'b1;
                            state_reg  <= S_HALT;
                        end
                    endcase
                end
                S_EXEC: begin
                    case (opcode)
                        OP_RTYPE: begin
                            if (funct_ok) begin
                                alu_reg   <= alu_res;
                                state_reg <= S_WB;
                            end else begin
                                halted_reg <= 1'b1;
                                state_reg  <= S_HALT;
                            end
                        end
                        OP_ADDI: begin
                            alu_reg   <= ea;
                            state_reg <= S_WB;
                        end
                        OP_LW, OP_SW: begin
                            alu_reg       <= ea;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= (opcode == OP_SW);
                            mem_addr_reg  <= ea[ADDR_W-1:0];
                            mem_wdata_reg <= (opcode == OP_SW) ? b_reg : mem_wdata_reg;
                            state_reg     <= S_MEM;
                        end
                        default: begin
                            // beq: resolve and issue the next fetch directly.
                            pc_reg       <= (a_reg == b_reg) ? target_reg : pc_reg;
                            mem_req_reg  <= 1'b1;
                            mem_we_reg   <= 1'b0;
                            mem_addr_reg <= (a_reg == b_reg) ? target_reg : pc_reg;
                            state_reg    <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (timeout_hit) begin
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        halted_reg  <= 1'b1;
                        state_reg   <= S_HALT;
                    end else if (mem.mem_ack) begin
                        mem_we_reg <= 1'b0;
                        if (opcode == OP_LW) begin
                            mdr_reg     <= mem.mem_rdata;
                            mem_req_reg <= 1'b0;
                            state_reg   <= S_WB;
                        end else begin
                            mem_req_reg  <= 1'b1;
                            mem_addr_reg <= pc_reg;
                            state_reg    <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    mem_req_reg  <= 1'b1;
                    mem_we_reg   <= 1'b0;
                    mem_addr_reg <= pc_reg;
                    state_reg    <= S_FETCH;
                end
                default: begin
                    mem_req_reg <= 1'b0;
                    mem_we_reg  <= 1'b0;
                    halted_reg  <= 1'b1;
                    state_reg   <= S_HALT;
                end
            endcase
        end
    end

    assign mem.mem_req   = mem_req_reg;
    assign mem.mem_we    = mem_we_reg;
    assign mem.mem_addr  = mem_addr_reg;
    assign mem.mem_wdata = mem_wdata_reg;
    assign pc_out        = pc_reg;
    assign state_out     = state_reg;
    assign halted        = halted_reg;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core with a variable-latency memory model.
module tb_mips_multicycle_core;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  pc_out;
    logic [2:0]  state_out;
    logic        halted;
    logic        err;

    mips_multicycle_core_if #(.ADDR_W(8)) bus ();

    mips_multicycle_core #(.ADDR_W(8), .RESET_PC(32'h0), .MEM_TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem       (bus),
        .pc_out    (pc_out),
        .state_out (state_out),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    logic [31:0] mem_arr [64];
    int          ack_delay = 0;
    bit          ack_off   = 1'b0;
    int          wcnt      = 0;
    logic [7:0]  fetch_q   [$];
    int          fetch_cyc [$];
    logic [7:0]  wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          wr_len_q  [$];

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } memchk_t;

    typedef struct {
        logic [7:0] addr;
        int         gap;
    } fetchchk_t;

    typedef struct {
        logic [31:0] word;
        string       name;
    } haltvec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) cycle <= 0;
        else      cycle <= cycle + 1;
    end

    // Memory model: ack after ack_delay wait cycles, one line per transaction.
    always @(negedge clk) begin
        if (!rst || !bus.mem_req) begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
        end else begin
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                wcnt = 0;
            end
            if (!ack_off && wcnt == ack_delay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_arr[bus.mem_addr[7:2]];
                if (bus.mem_we) begin
                    mem_arr[bus.mem_addr[7:2]] = bus.mem_wdata;
                    wr_addr_q.push_back(bus.mem_addr);
                    wr_data_q.push_back(bus.mem_wdata);
                    wr_len_q.push_back(wcnt + 1);
                    $display("cyc %0d write addr=%h data=%h", cycle, bus.mem_addr, bus.mem_wdata);
                end else begin
                    if (state_out == 3'd0) begin
                        fetch_q.push_back(bus.mem_addr);
                        fetch_cyc.push_back(cycle);
                    end
                    $display("cyc %0d read addr=%h data=%h", cycle, bus.mem_addr, bus.mem_rdata);
                end
            end else begin
                wcnt++;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem_arr[i] = 32'hDEAD_0000 | i;
    endtask

    task automatic hold_reset();
        rst = 1'b0;
        fetch_q.delete();
        fetch_cyc.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_len_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_until_halt(input string name, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, {31'd0, halted}, 32'd1);
    endtask

    task automatic wait_fetches(input int cnt, input int budget);
        int n = 0;
        while (fetch_q.size() < cnt && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("fetch_budget", 32'(fetch_q.size() >= cnt), 32'd1);
    endtask

    memchk_t   memchk_a [4];
    fetchchk_t fetch_c  [9];
    haltvec_t  halt_v   [3];

    initial begin
        memchk_a[0] = '{8'hC0, 32'd12};
        memchk_a[1] = '{8'hC4, 32'hFFFF_FFFE};
        memchk_a[2] = '{8'hC8, 32'd1};
        memchk_a[3] = '{8'hCC, 32'd0};

        fetch_c[0] = '{8'h00, 0};
        fetch_c[1] = '{8'h04, 4};
        fetch_c[2] = '{8'h08, 4};
        fetch_c[3] = '{8'h0C, 3};
        fetch_c[4] = '{8'h40, 2};
        fetch_c[5] = '{8'h10, 2};
        fetch_c[6] = '{8'h0C, 3};
        fetch_c[7] = '{8'h40, 2};
        fetch_c[8] = '{8'h10, 2};

        halt_v[0] = '{32'hFC00_0000, "halt_op"};
        halt_v[1] = '{32'h0000_003F, "bad_funct"};
        halt_v[2] = '{32'h0C00_0000, "bad_opcode"};

        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        // ---- Program A: ALU ops, zero-wait memory ----
        clear_mem();
        mem_arr[0]  = 32'h2001_0005;  // addi $1,$0,5
        mem_arr[1]  = 32'h2002_0007;  // addi $2,$0,7
        mem_arr[2]  = 32'h0022_1820;  // add  $3,$1,$2
        mem_arr[3]  = 32'h0022_2022;  // sub  $4,$1,$2
        mem_arr[4]  = 32'h0081_282A;  // slt  $5,$4,$1
        mem_arr[5]  = 32'h2000_0009;  // addi $0,$0,9
        mem_arr[6]  = 32'hAC03_00C0;  // sw $3,0xC0($0)
        mem_arr[7]  = 32'hAC04_00C4;  // sw $4,0xC4($0)
        mem_arr[8]  = 32'hAC05_00C8;  // sw $5,0xC8($0)
        mem_arr[9]  = 32'hAC00_00CC;  // sw $0,0xCC($0)
        mem_arr[10] = 32'hFC00_0000;  // halt
        ack_delay = 0;
        ack_off   = 1'b0;
        hold_reset();
        check("rst_req",   {31'd0, bus.mem_req}, 32'd0);
        check("rst_we",    {31'd0, bus.mem_we},  32'd0);
        check("rst_addr",  {24'd0, bus.mem_addr}, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_pc",    {24'd0, pc_out}, 32'd0);
        check("rst_state", {29'd0, state_out}, 32'd0);
        check("rst_halt",  {31'd0, halted}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        release_reset();
        repeat (12) @(posedge clk);
        #1;
        check("pc_after_3", {24'd0, pc_out}, 32'h0C);
        run_until_halt("a_halted", 300);
        check("a_state", {29'd0, state_out}, 32'd5);
        for (int i = 0; i < 4; i++)
            check($sformatf("a_mem_%h", memchk_a[i].addr), mem_arr[memchk_a[i].addr[7:2]], memchk_a[i].data);
        check("a_nfetch", fetch_q.size(), 32'd11);
        for (int i = 0; i < 11 && i < fetch_q.size(); i++) begin
            check($sformatf("a_faddr_%0d", i), {24'd0, fetch_q[i]}, 32'(i * 4));
            if (i > 0) check($sformatf("a_gap_%0d", i), fetch_cyc[i] - fetch_cyc[i-1], 32'd4);
        end
        begin
            int req_seen = 0;
            repeat (10) begin
                @(posedge clk);
                #1;
                if (bus.mem_req || !halted) req_seen++;
            end
            check("a_halt_stays", req_seen, 32'd0);
        end

        // ---- Program B: sw/lw with 3-cycle ack delay ----
        clear_mem();
        mem_arr[0] = 32'h2003_000C;  // addi $3,$0,12
        mem_arr[1] = 32'h1000_0001;  // beq $0,$0,+1 (skip data slot)
        mem_arr[3] = 32'hAC03_0008;  // sw $3,8($0)
        mem_arr[4] = 32'h8C06_0008;  // lw $6,8($0)
        mem_arr[5] = 32'hAC06_00C0;  // sw $6,0xC0($0)
        mem_arr[6] = 32'hFC00_0000;  // halt
        ack_delay = 3;
        hold_reset();
        release_reset();
        run_until_halt("b_halted", 400);
        check("b_nwrites", wr_addr_q.size(), 32'd2);
        if (wr_addr_q.size() >= 2) begin
            check("b_sw_addr", {24'd0, wr_addr_q[0]}, 32'h08);
            check("b_sw_data", wr_data_q[0], 32'd12);
            check("b_sw_reqlen", wr_len_q[0], 32'd4);
            check("b_lw_store_addr", {24'd0, wr_addr_q[1]}, 32'hC0);
        end
        check("b_lw_value", mem_arr[8'hC0 >> 2], 32'd12);
        check("b_fetch_skip", {24'd0, fetch_q[2]}, 32'h0C);

        // ---- Program C: beq taken/not taken and j, zero wait ----
        clear_mem();
        mem_arr[0]  = 32'h2001_0001;  // addi $1,$0,1
        mem_arr[1]  = 32'h2002_0002;  // addi $2,$0,2
        mem_arr[2]  = 32'h1022_0005;  // beq $1,$2,+5 (not taken)
        mem_arr[3]  = 32'h0800_0010;  // j 0x10 -> 0x40
        mem_arr[4]  = 32'h1021_FFFE;  // beq $1,$1,-2 -> 0x0C
        mem_arr[16] = 32'h0800_0004;  // j 0x04 -> 0x10
        ack_delay = 0;
        hold_reset();
        release_reset();
        wait_fetches(9, 300);
        for (int i = 0; i < 9 && i < fetch_q.size(); i++) begin
            check($sformatf("c_faddr_%0d", i), {24'd0, fetch_q[i]}, {24'd0, fetch_c[i].addr});
            if (i > 0) check($sformatf("c_gap_%0d", i), fetch_cyc[i] - fetch_cyc[i-1], fetch_c[i].gap);
        end

        // ---- Reset in the middle of a pending fetch ----
        ack_off = 1'b1;
        begin
            int n = 0;
            while (!(bus.mem_req && state_out == 3'd0) && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        check("mid_req_before", {31'd0, bus.mem_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_req",   {31'd0, bus.mem_req}, 32'd0);
        check("mid_rst_pc",    {24'd0, pc_out}, 32'd0);
        check("mid_rst_state", {29'd0, state_out}, 32'd0);
        check("mid_rst_addr",  {24'd0, bus.mem_addr}, 32'd0);
        ack_off = 1'b0;

        // ---- Halt vectors: halt opcode, bad funct, unsupported opcode ----
        for (int v = 0; v < 3; v++) begin
            clear_mem();
            mem_arr[0] = halt_v[v].word;
            hold_reset();
            release_reset();
            run_until_halt({halt_v[v].name, "_halted"}, 50);
            repeat (5) @(posedge clk);
            #1;
            check({halt_v[v].name, "_state"}, {29'd0, state_out}, 32'd5);
            check({halt_v[v].name, "_req"}, {31'd0, bus.mem_req}, 32'd0);
            check({halt_v[v].name, "_nfetch"}, fetch_q.size(), 32'd1);
        end

        // ---- Memory never acknowledges ----
        clear_mem();
        ack_off = 1'b1;
        hold_reset();
        release_reset();
        @(posedge clk);
        #1;
        check("to_req_up", {31'd0, bus.mem_req}, 32'd1);
`ifdef MC_TIMEOUT_EN
        repeat (14) @(posedge clk);
        #1;
        check("to_err_early", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        check("to_err",    {31'd0, err}, 32'd1);
        check("to_halted", {31'd0, halted}, 32'd1);
        check("to_req",    {31'd0, bus.mem_req}, 32'd0);
        check("to_state",  {29'd0, state_out}, 32'd5);
`else
        repeat (100) @(posedge clk);
        #1;
        check("wait_err",    {31'd0, err}, 32'd0);
        check("wait_req",    {31'd0, bus.mem_req}, 32'd1);
        check("wait_state",  {29'd0, state_out}, 32'd0);
        check("wait_halted", {31'd0, halted}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
